// File: rtl/sbuf_pkg.sv
// sbuf_pkg -- shared types and defaults for the ping-pong operand buffer.
//   bank_state_e : ownership state of one bank (EMPTY = loader owns it,
//                  FULL = array owns it)
//   SBUF_DW/AW   : default data width and per-bank address width
package sbuf_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_e;

    localparam int SBUF_DW = 16;
    localparam int SBUF_AW = 7;

endpackage : sbuf_pkg

// File: rtl/sbuf_bank.sv
// sbuf_bank -- one 1r1w RAM bank of 2**AW words of DW bits.
//   clk     : clock
//   rst_n   : asynchronous active-low reset (read data register only)
//   we_i    : write enable
//   wadr_i  : write address
//   wdata_i : write data
//   re_i    : read enable
//   radr_i  : read address
//   rdata_o : registered read data; holds its value while re_i is low
module sbuf_bank #(
    parameter int DW = 16,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] wadr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] radr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // Array contents carry no reset so the storage maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[wadr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[radr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : sbuf_bank

// File: rtl/sbuf_pingpong.sv
// sbuf_pingpong -- double-buffered operand buffer. The loader fills the
// bank selected by wr_sel while the array reads the bank selected by
// rd_sel; banks change owner through wr_done / rd_done.
//   clk, rst_n              : clock, asynchronous active-low reset
//   wr_en/wr_adr/wr_data    : write into current write bank
//   wr_done / wr_ready      : release write bank / write bank is EMPTY
//   rd_en/rd_adr            : read from current read bank
//   rd_data / rd_valid      : registered read data, valid one cycle later
//   rd_done / rd_ready      : release read bank / read bank is FULL
//   full_cnt                : number of FULL banks (0..2)
//   err_wr / err_rd         : sticky protocol-error flags
module sbuf_pingpong
    import sbuf_pkg::*;
#(
    parameter int DW = SBUF_DW,
    parameter int AW = SBUF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_adr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_done,
    output logic          wr_ready,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_adr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_done,
    output logic          rd_ready,
    output logic [1:0]    full_cnt,
    output logic          err_wr,
    output logic          err_rd
);

    bank_state_e   state_q [2];
    bank_state_e   state_d [2];
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_bank_q, rd_bank_d;   // bank whose read register drives rd_data
    logic          err_wr_q, err_wr_d;
    logic          err_rd_q, err_rd_d;
    logic          wr_fire, rd_fire, wr_release, rd_release;
    logic [DW-1:0] bank_rdata [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            sbuf_bank #(.DW(DW), .AW(AW)) u_bank (
                .clk     (clk),
                .rst_n   (rst_n),
                .we_i    (wr_fire && (wr_sel_q == 1'(gi))),
                .wadr_i  (wr_adr),
                .wdata_i (wr_data),
                .re_i    (rd_fire && (rd_sel_q == 1'(gi))),
                .radr_i  (rd_adr),
                .rdata_o (bank_rdata[gi])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= EMPTY;
            end
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= 1'b0;
            err_wr_q   <= 1'b0;
            err_rd_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
            end
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            rd_valid_q <= rd_valid_d;
            rd_bank_q  <= rd_bank_d;
            err_wr_q   <= err_wr_d;
            err_rd_q   <= err_rd_d;
        end
    end

    // Next-state logic. A bank can only be released by the loader while
    // EMPTY and by the array while FULL, so both releases never hit the
    // same bank in one cycle.
    always_comb begin
        wr_fire    = wr_en && wr_ready;
        rd_fire    = rd_en && rd_ready;
        wr_release = wr_done && wr_ready;
        rd_release = rd_done && rd_ready;

        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            if (wr_release && (wr_sel_q == 1'(i))) begin
                state_d[i] = FULL;
            end
            if (rd_release && (rd_sel_q == 1'(i))) begin
                state_d[i] = EMPTY;
            end
        end

        wr_sel_d   = wr_sel_q ^ wr_release;
        rd_sel_d   = rd_sel_q ^ rd_release;
        rd_valid_d = rd_fire;
        rd_bank_d  = rd_fire ? rd_sel_q : rd_bank_q;
        err_wr_d   = err_wr_q || ((wr_en || wr_done) && !wr_ready);
        err_rd_d   = err_rd_q || ((rd_en || rd_done) && !rd_ready);
    end

    // Outputs.
    always_comb begin
        wr_ready = (state_q[wr_sel_q] == EMPTY);
        rd_ready = (state_q[rd_sel_q] == FULL);
        full_cnt = {1'b0, state_q[0]} + {1'b0, state_q[1]};
        rd_data  = bank_rdata[rd_bank_q];
        rd_valid = rd_valid_q;
        err_wr   = err_wr_q;
        err_rd   = err_rd_q;
    end

endmodule : sbuf_pingpong

// File: tb/tb_sbuf_pingpong.sv
// tb_sbuf_pingpong -- directed self-checking bench for sbuf_pingpong.
module tb_sbuf_pingpong;

    localparam int DW = 16;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, wr_done, rd_en, rd_done;
    logic [AW-1:0] wr_adr, rd_adr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          wr_ready, rd_ready, rd_valid, err_wr, err_rd;
    logic [1:0]    full_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sbuf_pingpong #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_adr   (wr_adr),
        .wr_data  (wr_data),
        .wr_done  (wr_done),
        .wr_ready (wr_ready),
        .rd_en    (rd_en),
        .rd_adr   (rd_adr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_done  (rd_done),
        .rd_ready (rd_ready),
        .full_cnt (full_cnt),
        .err_wr   (err_wr),
        .err_rd   (err_rd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
        wr_adr = '0; rd_adr = '0; wr_data = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        tick();
    endtask

    // Fill the current write bank with base+adr, then release it.
    task automatic fill_bank(input logic [DW-1:0] base);
        for (int a = 0; a < 2**AW; a++) begin
            wr_en = 1; wr_adr = AW'(a); wr_data = base + DW'(a);
            tick();
        end
        wr_en = 0; wr_done = 1;
        tick();
        wr_done = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
        n_vec++; if (rd_ready !== 1'b0) begin n_err++; $display("FAIL reset_rd_ready got %b exp 0", rd_ready); end
        n_vec++; if (full_cnt !== 2'd0) begin n_err++; $display("FAIL reset_full_cnt got %0d exp 0", full_cnt); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        n_vec++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL reset_rd_data got %h exp 0000", rd_data); end
        n_vec++; if ({err_wr, err_rd} !== 2'b00) begin n_err++; $display("FAIL reset_errs got %b exp 00", {err_wr, err_rd}); end
        $display("test_reset done");
    endtask

    task automatic test_fill_read();
        fill_bank(16'h0100);
        n_vec++; if (full_cnt !== 2'd1) begin n_err++; $display("FAIL fill_full_cnt got %0d exp 1", full_cnt); end
        n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL fill_rd_ready got %b exp 1", rd_ready); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL fill_wr_ready got %b exp 1", wr_ready); end
        rd_en = 1; rd_adr = 7'd5;
        tick();
        rd_en = 0;
        n_vec++; if (rd_data !== 16'h0105) begin n_err++; $display("FAIL fill_rd_data got %h exp 0105", rd_data); end
        n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL fill_rd_valid got %b exp 1", rd_valid); end
        tick();
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL idle_rd_valid got %b exp 0", rd_valid); end
        n_vec++; if (rd_data !== 16'h0105) begin n_err++; $display("FAIL hold_rd_data got %h exp 0105", rd_data); end
        $display("test_fill_read done");
    endtask

    task automatic test_overlap();
        logic [DW-1:0] exp_d;
        for (int a = 0; a < 2**AW; a++) begin
            wr_en = 1; wr_adr = AW'(a); wr_data = 16'h2000 + DW'(a);
            rd_en = 1; rd_adr = AW'(a);
            tick();
            exp_d = 16'h0100 + DW'(a);
            n_vec++; if (rd_data !== exp_d || rd_valid !== 1'b1) begin
                n_err++; $display("FAIL overlap_rd adr %0d got %h/%b exp %h/1", a, rd_data, rd_valid, exp_d);
            end
        end
        wr_en = 0; rd_en = 0; wr_done = 1; rd_done = 1;
        tick();
        wr_done = 0; rd_done = 0;
        n_vec++; if (full_cnt !== 2'd1) begin n_err++; $display("FAIL swap_full_cnt got %0d exp 1", full_cnt); end
        n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL swap_rd_ready got %b exp 1", rd_ready); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL swap_wr_ready got %b exp 1", wr_ready); end
        rd_en = 1; rd_adr = 7'd3;
        tick();
        rd_en = 0;
        n_vec++; if (rd_data !== 16'h2003) begin n_err++; $display("FAIL swap_rd_data got %h exp 2003", rd_data); end
        $display("test_overlap done");
    endtask

    // Entry state: bank0 EMPTY (write side), bank1 FULL (read side).
    task automatic test_overflow();
        fill_bank(16'h3000);
        n_vec++; if (full_cnt !== 2'd2) begin n_err++; $display("FAIL ovf_full_cnt got %0d exp 2", full_cnt); end
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL ovf_wr_ready got %b exp 0", wr_ready); end
        n_vec++; if (err_wr !== 1'b0) begin n_err++; $display("FAIL ovf_err_wr_pre got %b exp 0", err_wr); end
        wr_en = 1; wr_adr = 7'd0; wr_data = 16'hDEAD;
        tick();
        wr_en = 0;
        n_vec++; if (err_wr !== 1'b1) begin n_err++; $display("FAIL ovf_err_wr got %b exp 1", err_wr); end
        n_vec++; if (full_cnt !== 2'd2) begin n_err++; $display("FAIL ovf_full_cnt_post got %0d exp 2", full_cnt); end
        // Blocked write targeted bank1, which is the current read bank.
        rd_en = 1; rd_adr = 7'd0;
        tick();
        rd_en = 0;
        n_vec++; if (rd_data !== 16'h2000) begin n_err++; $display("FAIL ovf_rd_data got %h exp 2000", rd_data); end
        n_vec++; if (err_rd !== 1'b0) begin n_err++; $display("FAIL ovf_err_rd got %b exp 0", err_rd); end
        $display("test_overflow done");
    endtask

    task automatic test_underflow();
        apply_reset();
        rd_en = 1; rd_adr = 7'd0;
        tick();
        rd_en = 0;
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL udf_rd_valid got %b exp 0", rd_valid); end
        n_vec++; if (err_rd !== 1'b1) begin n_err++; $display("FAIL udf_err_rd got %b exp 1", err_rd); end
        rd_done = 1;
        tick();
        rd_done = 0;
        n_vec++; if (full_cnt !== 2'd0 || rd_ready !== 1'b0 || wr_ready !== 1'b1) begin
            n_err++; $display("FAIL udf_state got cnt %0d rdy %b/%b exp 0 0/1", full_cnt, rd_ready, wr_ready);
        end
        n_vec++; if (err_wr !== 1'b0) begin n_err++; $display("FAIL udf_err_wr got %b exp 0", err_wr); end
        $display("test_underflow done");
    endtask

    task automatic test_read_release();
        fill_bank(16'h4000);
        rd_en = 1; rd_adr = 7'd7; rd_done = 1;
        tick();
        rd_en = 0; rd_done = 0;
        n_vec++; if (rd_data !== 16'h4007) begin n_err++; $display("FAIL rr_rd_data got %h exp 4007", rd_data); end
        n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL rr_rd_valid got %b exp 1", rd_valid); end
        n_vec++; if (full_cnt !== 2'd0) begin n_err++; $display("FAIL rr_full_cnt got %0d exp 0", full_cnt); end
        n_vec++; if (rd_ready !== 1'b0) begin n_err++; $display("FAIL rr_rd_ready got %b exp 0", rd_ready); end
        $display("test_read_release done");
    endtask

    // Entry state: both banks EMPTY, wr_sel = 1, rd_sel = 1, err_rd set.
    task automatic test_async_reset();
        fill_bank(16'h5000);           // bank1 FULL
        wr_en = 1; wr_adr = 7'd0; wr_data = 16'h6000;
        rd_en = 1; rd_adr = 7'd9;
        tick();
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 16'h5009 || full_cnt !== 2'd1) begin
            n_err++; $display("FAIL ar_pre got %b %h %0d exp 1 5009 1", rd_valid, rd_data, full_cnt);
        end
        #1 rst_n = 0;                  // between clock edges
        #1;
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL ar_rd_valid got %b exp 0", rd_valid); end
        n_vec++; if (rd_data !== 16'h0000) begin n_err++; $display("FAIL ar_rd_data got %h exp 0000", rd_data); end
        n_vec++; if (full_cnt !== 2'd0) begin n_err++; $display("FAIL ar_full_cnt got %0d exp 0", full_cnt); end
        n_vec++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin
            n_err++; $display("FAIL ar_ready got %b/%b exp 1/0", wr_ready, rd_ready);
        end
        n_vec++; if ({err_wr, err_rd} !== 2'b00) begin n_err++; $display("FAIL ar_errs got %b exp 00", {err_wr, err_rd}); end
        idle_inputs();
        #1 rst_n = 1;
        tick();
        $display("test_async_reset done");
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_fill_read();
        test_overlap();
        test_overflow();
        test_underflow();
        test_read_release();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sbuf_pingpong
